digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry.sv | 142 ++++++++++++++
 tb/tb_digit_entry.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// Nine-button digit/operator entry: sync, debounce, BCD digit counters, operator strobe.
// Optional macro DIGIT_ENTRY_AUTOREPEAT_EN adds auto-repeat on the four digit buttons.
module digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] btn_in,
  output logic [3:0] digit_a1,
  output logic [3:0] digit_a0,
  output logic [3:0] digit_b1,
  output logic [3:0] digit_b0,
  output logic [6:0] operand_a,
  output logic [6:0] operand_b,
  output logic [2:0] op_code,
  output logic       op_valid
);

  localparam int unsigned NB = 9;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    rst_sync;
  logic          rst_i_n;
  logic [NB-1:0] sync1, sync2, deb, deb_next, armed, rise, press, press_next;
  logic [1:0]    warm;
  logic [DW-1:0] cnt      [NB];
  logic [DW-1:0] cnt_next [NB];
  logic [2:0]    op_sel;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Async assert, clock-synchronous release of the internal reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  always_comb begin
    deb_next = deb;
    for (int b = 0; b < NB; b++) begin
      cnt_next[b] = '0;
      if (sync2[b] != deb[b]) begin
        if (cnt[b] == DB_LAST) deb_next[b] = sync2[b];
        else                   cnt_next[b] = cnt[b] + DW'(1);
      end
    end
  end

  // A button must be seen released after reset before its rise counts as a press
  assign rise = deb_next & ~deb & armed;

`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt [4];
  logic [3:0]    rep_hit;

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 4; i++)
      rep_hit[i] = deb[i] & armed[i] & (rcnt[i] == RP_LAST);
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      for (int i = 0; i < 4; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!(deb[i] & armed[i]) || rep_hit[i]) rcnt[i] <= '0;
        else                                    rcnt[i] <= rcnt[i] + RW'(1);
      end
    end
  end

  assign press_next = rise | {5'b0, rep_hit};
`else
  // Repeat period only matters when the repeat counters exist
  if (REPEAT_CYCLES == 0) begin : g_repeat_unused
  end
  assign press_next = rise;
`endif

  // Synchronizers, debounce state and press pulses
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      armed <= '0;
      warm  <= '0;
      press <= '0;
      for (int b = 0; b < NB; b++) cnt[b] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      deb   <= deb_next;
      warm  <= {warm[0], 1'b1};
      armed <= armed | ({NB{warm[1]}} & ~sync2);
      press <= press_next;
      for (int b = 0; b < NB; b++) cnt[b] <= cnt_next[b];
    end
  end

  always_comb begin
    op_sel = 3'd0;
    if      (press[4]) op_sel = 3'd0;
    else if (press[5]) op_sel = 3'd1;
    else if (press[6]) op_sel = 3'd2;
    else if (press[7]) op_sel = 3'd3;
    else if (press[8]) op_sel = 3'd4;
  end

  // Digits, operands and operator strobe
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      digit_a1  <= '0;
      digit_a0  <= '0;
      digit_b1  <= '0;
      digit_b0  <= '0;
      operand_a <= '0;
      operand_b <= '0;
      op_code   <= '0;
      op_valid  <= 1'b0;
    end else begin
      if (press[0]) digit_a1 <= bcd_inc(digit_a1);
      if (press[1]) digit_a0 <= bcd_inc(digit_a0);
      if (press[2]) digit_b1 <= bcd_inc(digit_b1);
      if (press[3]) digit_b0 <= bcd_inc(digit_b0);
      operand_a <= 7'(digit_a1) * 7'd10 + 7'(digit_a0);
      operand_b <= 7'(digit_b1) * 7'd10 + 7'(digit_b0);
      op_valid  <= |press[8:4];
      if (|press[8:4]) op_code <= op_sel;
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: cycle model of the button rules plus directed scenarios.
module tb_digit_entry;

  localparam int unsigned DB = 4;
  localparam int unsigned RP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] btn = '0;
  logic [3:0] digit_a1, digit_a0, digit_b1, digit_b0;
  logic [6:0] operand_a, operand_b;
  logic [2:0] op_code;
  logic       op_valid;

  always #5 clk = ~clk;

  digit_entry #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .digit_a1(digit_a1), .digit_a0(digit_a0), .digit_b1(digit_b1), .digit_b0(digit_b0),
    .operand_a(operand_a), .operand_b(operand_b),
    .op_code(op_code), .op_valid(op_valid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples -> two-stage delay -> "last DB samples all disagree" debounce
  int       m_a1, m_a0, m_b1, m_b0, m_opa, m_opb, m_code, m_strobes;
  bit       m_valid;
  bit [8:0] m_s1, m_s2, m_deb, m_seen, m_pend;
  bit       m_hist [9][DB];
  int       m_age [4];
  int       rstc, fcnt;

  task automatic m_clear();
    m_a1 = 0; m_a0 = 0; m_b1 = 0; m_b0 = 0;
    m_opa = 0; m_opb = 0; m_code = 0; m_valid = 0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_seen = '0; m_pend = '0;
    fcnt = 0;
    for (int b = 0; b < 9; b++)
      for (int j = 0; j < DB; j++) m_hist[b][j] = 0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
  endtask

  task automatic m_step();
    bit [8:0] rise;
    bit all_diff, rep;
    fcnt++;
    m_opa = 10 * m_a1 + m_a0;
    m_opb = 10 * m_b1 + m_b0;
    m_valid = 0;
    for (int k = 4; k < 9; k++)
      if (m_pend[k] && !m_valid) begin
        m_valid = 1;
        m_code = k - 4;
        m_strobes++;
      end
    if (m_pend[0]) m_a1 = (m_a1 + 1) % 10;
    if (m_pend[1]) m_a0 = (m_a0 + 1) % 10;
    if (m_pend[2]) m_b1 = (m_b1 + 1) % 10;
    if (m_pend[3]) m_b0 = (m_b0 + 1) % 10;
    rise = '0;
    for (int b = 0; b < 9; b++) begin
      for (int j = DB - 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      m_hist[b][0] = m_s2[b];
      all_diff = 1;
      for (int j = 0; j < DB; j++) if (m_hist[b][j] == m_deb[b]) all_diff = 0;
      rep = 0;
`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
      if (b < 4) begin
        if (m_deb[b] && m_seen[b]) begin
          m_age[b]++;
          if (m_age[b] == RP) begin
            rep = 1;
            m_age[b] = 0;
          end
        end else m_age[b] = 0;
      end
`endif
      rise[b] = (all_diff && !m_deb[b] && m_seen[b]) || rep;
      if (all_diff) m_deb[b] = !m_deb[b];
      if (fcnt >= 3 && !m_s2[b]) m_seen[b] = 1;
    end
    m_pend = rise;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  initial begin
    m_strobes = 0;
    rstc = 0;
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
        rstc = 0;
      end else if (rstc < 2) begin
        rstc++;
        m_clear();
      end else m_step();
    end
  end

  // Per-cycle compare and strobe capture
  int       d_strobes = 0;
  int       cap_code, cap_a, cap_b;

  initial begin
    forever begin
      @(negedge clk);
      check("digit_a1", digit_a1, m_a1);
      check("digit_a0", digit_a0, m_a0);
      check("digit_b1", digit_b1, m_b1);
      check("digit_b0", digit_b0, m_b0);
      check("operand_a", operand_a, m_opa);
      check("operand_b", operand_b, m_opb);
      check("op_code", op_code, m_code);
      check("op_valid", op_valid, m_valid);
      if (op_valid === 1'b1) begin
        d_strobes++;
        cap_code = op_code;
        cap_a = operand_a;
        cap_b = operand_b;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cyc(8);
    btn[b] = 1'b0;
    cyc(8);
  endtask

  task automatic do_reset(input int low);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (low) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int base, mbase;
  bit found;

  initial begin
    cyc(2);
    check("rst_digit_a1", digit_a1, 0);
    check("rst_operand_a", operand_a, 0);
    check("rst_op_code", op_code, 0);
    check("rst_op_valid", op_valid, 0);
    #1 rst_n = 1'b1;
    cyc(6);

    // Bounce: 1,0,1 at 2-cycle spacing, then held 10 cycles
    btn[0] = 1; cyc(2);
    btn[0] = 0; cyc(2);
    btn[0] = 1; cyc(10);
    btn[0] = 0; cyc(8);
    check("bounce_digit_a1", digit_a1, 1);
    check("bounce_model_a1", m_a1, 1);

    // Ten presses of B4: wrap 9 -> 0 without carry
    for (int i = 1; i <= 10; i++) begin
      press(3);
      if (i == 9)  check("wrap_b0_after9", digit_b0, 9);
      if (i == 10) check("wrap_b0_after10", digit_b0, 0);
    end
    check("wrap_b1_stays", digit_b1, 0);

    // A=47, B=08, then multiply
    for (int i = 0; i < 3; i++) press(0);
    for (int i = 0; i < 7; i++) press(1);
    for (int i = 0; i < 8; i++) press(3);
    check("setup_operand_a", operand_a, 47);
    check("setup_operand_b", operand_b, 8);
    base = d_strobes;
    mbase = m_strobes;
    press(6);
    check("mul_strobes", d_strobes - base, 1);
    check("mul_model_strobes", m_strobes - mbase, 1);
    check("mul_code", cap_code, 2);
    check("mul_a", cap_a, 47);
    check("mul_b", cap_b, 8);

    // B6 and B8 together: subtract wins, single strobe
    base = d_strobes;
    btn[5] = 1; btn[7] = 1; cyc(8);
    btn[5] = 0; btn[7] = 0; cyc(12);
    check("prio_strobes", d_strobes - base, 1);
    check("prio_code", cap_code, 1);
    check("prio_hold_code", op_code, 1);

    // Digit and operator together: strobe carries pre-increment operand
    base = d_strobes;
    btn[0] = 1; btn[4] = 1; cyc(8);
    btn[0] = 0; btn[4] = 0; cyc(8);
    check("same_strobes", d_strobes - base, 1);
    check("same_code", cap_code, 0);
    check("same_a_pre", cap_a, 47);
    check("same_a_post", operand_a, 57);

    // Reset while B2 is two cycles into debounce; B2 held through release
    btn[1] = 1; cyc(3);
    do_reset(2);
    cyc(20);
    check("rstpress_a0_held", digit_a0, 0);
    check("rstpress_a1_cleared", digit_a1, 0);
    btn[1] = 0; cyc(10);
    check("rstpress_a0_released", digit_a0, 0);
    press(1);
    check("rstpress_a0_repress", digit_a0, 1);

    // Reset during the op_valid cycle of B9, B9 held through release
    btn[8] = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) found = 1;
    end
    check("opreset_strobe_seen", found, 1);
    #1 rst_n = 1'b0;
    cyc(2);
    #1 rst_n = 1'b1;
    cyc(20);
    base = d_strobes;
    btn[8] = 0; cyc(20);
    check("opreset_no_strobe", d_strobes - base, 0);
    check("opreset_code", op_code, 0);

    // B3 held 40 cycles beyond debounce
    btn[2] = 1; cyc(46);
    btn[2] = 0; cyc(10);
`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
    check("hold_digit_b1", digit_b1, 3);
`else
    check("hold_digit_b1", digit_b1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
